// File: rtl/load_pkg.sv
// Shared types for the load sequencer: load encodings, completion codes and FSM states.
package load_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_ILL = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_EXT  = 2'b10,
    S_FIN  = 2'b11
  } state_e;

  // Request-time check; illegal encoding takes priority over alignment.
  function automatic err_e load_check(logic [2:0] f3, logic [2:0] off);
    err_e res;
    res = ERR_OK;
    case (funct3_e'(f3))
      F3_ILL:         res = ERR_ILLEGAL;
      F3_LH, F3_LHU:  res = (off[0] != 1'b0) ? ERR_MISALIGN : ERR_OK;
      F3_LW, F3_LWU:  res = (off[1:0] != 2'b00) ? ERR_MISALIGN : ERR_OK;
      F3_LD:          res = (off != 3'b000) ? ERR_MISALIGN : ERR_OK;
      default:        res = ERR_OK;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half/word/double out of a little-endian doubleword
// and sign- or zero-extends it to 64 bits.
module load_extend
  import load_pkg::*;
(
  input  logic [63:0] dw,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] ext
);

  logic [63:0] shifted;

  assign shifted = dw >> {offset, 3'b000};

  always_comb begin
    ext = shifted;
    case (funct3_e'(funct3))
      F3_LB:   ext = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   ext = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   ext = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  ext = {56'd0, shifted[7:0]};
      F3_LHU:  ext = {48'd0, shifted[15:0]};
      F3_LWU:  ext = {32'd0, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// Load sequencer: checks the request, issues one doubleword read with a bounded
// wait for mem_ack, then extends the addressed field into load_data.
//
// state  | meaning
// IDLE   | waiting for start; request is checked here
// REQ    | mem_req asserted, counting cycles until mem_ack or timeout
// EXT    | extend captured doubleword into load_data
// FIN    | done pulse with err code, then back to IDLE
module load_seq_ctrl
  import load_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] load_data,
  output logic [1:0]  err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e      state;
  logic [CW-1:0] cnt;
  logic [2:0]  f3_q;
  logic [2:0]  off_q;
  logic [63:0] rdata_q;
  logic [63:0] ext_val;
  err_e        chk;

  assign chk = load_check(funct3, addr[2:0]);

  load_extend u_extend (
    .dw     (rdata_q),
    .offset (off_q),
    .funct3 (f3_q),
    .ext    (ext_val)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      off_q     <= 3'b000;
      rdata_q   <= 64'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 64'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      load_data <= 64'd0;
      err       <= ERR_OK;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            f3_q  <= funct3;
            off_q <= addr[2:0];
            cnt   <= '0;
            busy  <= 1'b1;
            if (chk != ERR_OK) begin
              err   <= chk;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              mem_addr <= {addr[63:3], 3'b000};
              mem_req  <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // An ack on the final counted cycle still completes the load.
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_EXT;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            err     <= ERR_TIMEOUT;
            done    <= 1'b1;
            state   <= S_FIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EXT: begin
          load_data <= ext_val;
          err       <= ERR_OK;
          done      <= 1'b1;
          state     <= S_FIN;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_seq_ctrl.sv
// Bench for load_seq_ctrl: directed vector table, reset-in-flight sequence and
// randomized loads checked against a byte-level reference model.
module tb_load_seq_ctrl;

  localparam int TO = 15;
  localparam logic [63:0] DATA = 64'h0123456789ABCDEF;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [63:0] load_data;
  logic [1:0]  err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] cur_ld;

  load_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .funct3    (funct3),
    .addr      (addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .load_data (load_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-wise gather from the little-endian doubleword.
  function automatic logic [1:0] model_err(logic [2:0] f3, logic [63:0] a);
    int nbytes;
    if (f3 == 3'b111) return 2'b10;
    nbytes = 1 << f3[1:0];
    if ((int'(a[2:0]) % nbytes) != 0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] model_val(logic [2:0] f3, logic [63:0] a, logic [63:0] d);
    int off;
    int nbytes;
    logic [63:0] v;
    off = int'(a[2:0]);
    nbytes = 1 << f3[1:0];
    v = 64'd0;
    for (int i = 0; i < nbytes; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
    if (!f3[2] && nbytes < 8 && v[8*nbytes-1])
      for (int i = nbytes; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Called at a negedge; start is sampled at the next rising edge (cycle 0).
  // k is the cycle carrying mem_ack (-1 = never).
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] d, input int k, input bit noise, input bit hold,
                          input logic [1:0] exp_err, input logic [63:0] exp_ld);
    int cyc;
    int req_n;
    int exp_done;
    int exp_req;
    bit got;
    bit maddr_bad;
    logic busy_at_done;
    if (exp_err == 2'b01 || exp_err == 2'b10) begin
      exp_done = 1; exp_req = 0;
    end else if (exp_err == 2'b11) begin
      exp_done = TO + 1; exp_req = TO;
    end else begin
      exp_done = k + 2; exp_req = k;
    end
    start = 1'b1;
    funct3 = f3;
    addr = a;
    mem_ack = noise;
    mem_rdata = {$urandom, $urandom};
    got = 1'b0;
    req_n = 0;
    maddr_bad = 1'b0;
    busy_at_done = 1'b0;
    for (cyc = 0; cyc < TO + 8; cyc++) begin
      if (cyc > 0) begin
        if (mem_req) begin
          req_n++;
          if (mem_addr !== (a & ~64'h7)) maddr_bad = 1'b1;
        end
        if (done) begin
          got = 1'b1;
          busy_at_done = busy;
          break;
        end
        start = hold;
        if (hold) begin
          funct3 = 3'b111;
          addr = {$urandom, $urandom};
        end
        mem_ack = (cyc == k) || (noise && cyc == k + 1);
        mem_rdata = (cyc == k) ? d : {$urandom, $urandom};
      end
      @(negedge clk);
    end
    start = 1'b0;
    mem_ack = 1'b0;
    funct3 = 3'b000;
    check({tag, " done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, " done_cycle"}, 64'(cyc), 64'(exp_done));
      check({tag, " err"}, 64'(err), 64'(exp_err));
      check({tag, " load_data"}, load_data, exp_ld);
      check({tag, " req_cycles"}, 64'(req_n), 64'(exp_req));
      check({tag, " mem_addr"}, 64'(maddr_bad), 64'd0);
      check({tag, " busy_at_done"}, 64'(busy_at_done), 64'd1);
    end
    @(negedge clk);
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    int          k;
    logic [1:0]  e;
    logic [63:0] ld;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int done_cnt;
    logic [2:0]  rf3;
    logic [63:0] ra;
    logic [63:0] rd;
    int          rk;
    logic [1:0]  re;
    logic [63:0] rl;

    tbl[0]  = '{3'b010, 64'h1000,  2, 2'b00, 64'hFFFFFFFF89ABCDEF};
    tbl[1]  = '{3'b110, 64'h1000,  2, 2'b00, 64'h0000000089ABCDEF};
    tbl[2]  = '{3'b010, 64'h1004,  3, 2'b00, 64'h0000000001234567};
    tbl[3]  = '{3'b000, 64'h1001,  1, 2'b00, 64'hFFFFFFFFFFFFFFCD};
    tbl[4]  = '{3'b100, 64'h1001,  2, 2'b00, 64'h00000000000000CD};
    tbl[5]  = '{3'b001, 64'h1003,  2, 2'b01, 64'h00000000000000CD};
    tbl[6]  = '{3'b111, 64'h1000,  2, 2'b10, 64'h00000000000000CD};
    tbl[7]  = '{3'b011, 64'h2000, -1, 2'b11, 64'h00000000000000CD};
    tbl[8]  = '{3'b011, 64'h1000, TO, 2'b00, 64'h0123456789ABCDEF};
    tbl[9]  = '{3'b001, 64'h1002,  4, 2'b00, 64'hFFFFFFFFFFFF89AB};
    tbl[10] = '{3'b101, 64'h1006,  1, 2'b00, 64'h0000000000000123};
    tbl[11] = '{3'b011, 64'h1004,  2, 2'b01, 64'h0000000000000123};
    tbl[12] = '{3'b000, 64'h1007,  5, 2'b00, 64'h0000000000000001};
    tbl[13] = '{3'b110, 64'h1002,  2, 2'b01, 64'h0000000000000001};

    reset_n = 1'b0;
    start = 1'b0;
    funct3 = 3'b000;
    addr = 64'd0;
    mem_ack = 1'b0;
    mem_rdata = 64'd0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst mem_req", 64'(mem_req), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst load_data", load_data, 64'd0);
    check("rst mem_addr", mem_addr, 64'd0);

    // First start lands on the very first rising edge after release.
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++)
      run_load($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, DATA, tbl[i].k,
               (i == 3 || i == 10), (i == 4 || i == 9), tbl[i].e, tbl[i].ld);

    // Reset while waiting for mem_ack.
    start = 1'b1; funct3 = 3'b011; addr = 64'h3000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrst req_before", 64'(mem_req), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst mem_req", 64'(mem_req), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst load_data", load_data, 64'd0);
    check("midrst mem_addr", mem_addr, 64'd0);
    check("midrst err", 64'(err), 64'd0);
    done_cnt = 0;
    mem_ack = 1'b1;
    mem_rdata = DATA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    mem_ack = 1'b0;
    check("midrst no_done", 64'(done_cnt), 64'd0);
    reset_n = 1'b1;
    run_load("after_rst", 3'b011, 64'h3008, 64'hFEDCBA9876543210, 3, 1'b0, 1'b0,
             2'b00, 64'hFEDCBA9876543210);
    cur_ld = 64'hFEDCBA9876543210;

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      rk = $urandom_range(0, TO + 2);
      if (rk == 0) rk = -1;
      re = model_err(rf3, ra);
      if (re == 2'b00 && (rk < 1 || rk > TO)) re = 2'b11;
      rl = (re == 2'b00) ? model_val(rf3, ra, rd) : cur_ld;
      run_load($sformatf("rnd%0d", i), rf3, ra, rd, rk, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), re, rl);
      cur_ld = rl;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
